// File: rtl/vfd_capture_if.sv
// VFD capture port bundle: CPU port sampler inputs, frame sweep
// control and the renderer's row-addressed read port.
interface vfd_capture_if #(
    parameter int NGRID = 12,
    parameter int NSEG  = 16
) ();
    logic             ce;
    logic [NGRID-1:0] grid_in;
    logic [NSEG-1:0]  seg_in;
    logic             frame_tick;
    logic [3:0]       rd_addr;
    logic [NSEG-1:0]  rd_seg;
    logic             busy;
    logic             ovr;

    modport master (
        output ce, grid_in, seg_in, frame_tick, rd_addr,
        input  rd_seg, busy, ovr
    );

    modport slave (
        input  ce, grid_in, seg_in, frame_tick, rd_addr,
        output rd_seg, busy, ovr
    );
endinterface

// File: rtl/vfd_capture.sv
// VFD grid/segment capture with settle filter, per-cell phosphor
// persistence levels, frame-driven decay sweep and registered read.
module vfd_capture #(
    parameter int NGRID  = 12,
    parameter int NSEG   = 16,
    parameter int SETTLE = 3,
    parameter int DECAY  = 4
) (
    input logic         clk,
    input logic         reset,
    vfd_capture_if.slave bus
);
    localparam logic [3:0] DEC    = 4'(DECAY);
    localparam logic [3:0] SET    = 4'(SETTLE);
    localparam logic [3:0] SET_M1 = 4'(SETTLE - 1);
    localparam logic [3:0] LAST   = 4'(NGRID - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state, state_n;
    logic [3:0]       row, row_n;
    logic             ovr_q, ovr_n;
    logic [NGRID-1:0] grid_q;
    logic [NSEG-1:0]  seg_q;
    logic [3:0]       stab;
    logic             same;
    logic             capture;
    logic [3:0]       level [NGRID][NSEG];
    logic [NSEG-1:0]  row_lit;

    assign same    = {bus.grid_in, bus.seg_in} == {grid_q, seg_q};
    assign capture = bus.ce && same && (stab == SET_M1);
    assign bus.busy = (state == SWEEP);
    assign bus.ovr  = ovr_q;

    // Settle filter: one capture per stable period of port state.
    always_ff @(posedge clk) begin
        if (reset) begin
            grid_q <= '0;
            seg_q  <= '0;
            stab   <= '0;
        end else if (bus.ce) begin
            if (!same) begin
                grid_q <= bus.grid_in;
                seg_q  <= bus.seg_in;
                stab   <= '0;
            end else if (stab != SET) begin
                stab <= stab + 4'd1;
            end
        end
    end

    // Sweep state, row pointer and sticky overrun registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            row   <= '0;
            ovr_q <= 1'b0;
        end else begin
            state <= state_n;
            row   <= row_n;
            ovr_q <= ovr_n;
        end
    end

    // Sweep next-state: one row per clock, ticks during a sweep overrun.
    always_comb begin
        state_n = state;
        row_n   = row;
        ovr_n   = ovr_q;
        unique case (state)
            IDLE: begin
                if (bus.frame_tick) begin
                    state_n = SWEEP;
                    row_n   = '0;
                end
            end
            SWEEP: begin
                if (bus.frame_tick) ovr_n = 1'b1;
                if (row == LAST) state_n = IDLE;
                else row_n = row + 4'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    // Level store: capture reloads DECAY and beats a same-cell decrement.
    always_ff @(posedge clk) begin
        for (int g = 0; g < NGRID; g++) begin
            for (int s = 0; s < NSEG; s++) begin
                if (reset) begin
                    level[g][s] <= '0;
                end else if (capture && bus.grid_in[g] && bus.seg_in[s]) begin
                    level[g][s] <= DEC;
                end else if (state == SWEEP && int'(row) == g
                             && level[g][s] != 4'd0) begin
                    level[g][s] <= level[g][s] - 4'd1;
                end
            end
        end
    end

    // Row mux for the read port; out-of-range rows read as dark.
    always_comb begin
        row_lit = '0;
        for (int g = 0; g < NGRID; g++) begin
            if (int'(bus.rd_addr) == g) begin
                for (int s = 0; s < NSEG; s++) begin
                    row_lit[s] = (level[g][s] != 4'd0);
                end
            end
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (reset) bus.rd_seg <= '0;
        else bus.rd_seg <= row_lit;
    end
endmodule

// File: tb/tb_vfd_capture.sv
// Directed bench for vfd_capture: capture, glitch rejection, decay,
// multi-grid, collision/overrun and reset mid-sweep.
module tb_vfd_capture;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;
    int cnt;

    always #5 clk = ~clk;

    vfd_capture_if #(.NGRID(12), .NSEG(16)) bus ();

    vfd_capture #(
        .NGRID(12), .NSEG(16), .SETTLE(3), .DECAY(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic clkn(input int n);
        for (int i = 0; i < n; i++) clk1();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clkn(2);
        reset = 1'b0;
    endtask

    // One frame tick, then count busy over the next 20 clocks.
    task automatic sweep(output int n);
        bus.frame_tick = 1'b1;
        clk1();
        bus.frame_tick = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.busy) n++;
            clk1();
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.ce = 1'b0;
        bus.grid_in = '0;
        bus.seg_in = '0;
        bus.frame_tick = 1'b0;
        bus.rd_addr = 4'd0;
        do_reset();
        chk("rst_rd_seg", 32'(bus.rd_seg), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_ovr", 32'(bus.ovr), 32'h0);

        // 1: capture on 4th ce with ce every 4th clock
        bus.grid_in = 12'h001;
        bus.seg_in = 16'h8001;
        for (int i = 1; i <= 4; i++) begin
            clkn(3);
            bus.ce = 1'b1;
            clk1();
            bus.ce = 1'b0;
            chk($sformatf("t1_ce%0d", i), 32'(bus.rd_seg), 32'h0);
        end
        clk1();
        chk("t1_after", 32'(bus.rd_seg), 32'h8001);

        // 3: four decay sweeps of 12 clocks each
        for (int i = 1; i <= 4; i++) begin
            sweep(cnt);
            chk($sformatf("t3_busy%0d", i), 32'(cnt), 32'd12);
            chk($sformatf("t3_rd%0d", i), 32'(bus.rd_seg),
                (i < 4) ? 32'h8001 : 32'h0);
        end
        chk("t3_ovr", 32'(bus.ovr), 32'h0);

        // 2: glitch at ce#3 restarts the settle count
        do_reset();
        bus.seg_in = 16'h8001;
        for (int i = 1; i <= 7; i++) begin
            bus.seg_in = (i == 3) ? 16'h8003 : 16'h8001;
            clkn(3);
            bus.ce = 1'b1;
            clk1();
            bus.ce = 1'b0;
            chk($sformatf("t2_ce%0d", i), 32'(bus.rd_seg), 32'h0);
        end
        clk1();
        chk("t2_after", 32'(bus.rd_seg), 32'h8001);

        // 4: two grids, four segments
        bus.grid_in = 12'h0C0;
        bus.seg_in = 16'h00F0;
        bus.ce = 1'b1;
        clkn(4);
        bus.ce = 1'b0;
        bus.rd_addr = 4'd6;  clk1(); chk("t4_r6", 32'(bus.rd_seg), 32'h00F0);
        bus.rd_addr = 4'd7;  clk1(); chk("t4_r7", 32'(bus.rd_seg), 32'h00F0);
        bus.rd_addr = 4'd5;  clk1(); chk("t4_r5", 32'(bus.rd_seg), 32'h0);
        bus.rd_addr = 4'd8;  clk1(); chk("t4_r8", 32'(bus.rd_seg), 32'h0);
        bus.rd_addr = 4'd12; clk1(); chk("t4_r12", 32'(bus.rd_seg), 32'h0);
        bus.rd_addr = 4'd0;  clk1(); chk("t4_r0", 32'(bus.rd_seg), 32'h8001);

        // 5: bring row0 to level 1, then collide capture with row0 sweep
        do_reset();
        bus.grid_in = 12'h001;
        bus.seg_in = 16'h8001;
        bus.ce = 1'b1;
        clkn(4);
        bus.ce = 1'b0;
        for (int i = 0; i < 3; i++) sweep(cnt);
        chk("t5_lvl1", 32'(bus.rd_seg), 32'h8001);
        chk("t5_ovr0", 32'(bus.ovr), 32'h0);
        bus.ce = 1'b1;
        bus.grid_in = '0;
        bus.seg_in = '0;
        clk1();
        bus.grid_in = 12'h001;
        bus.seg_in = 16'h8001;
        clkn(2);
        bus.frame_tick = 1'b1;
        clk1();
        bus.frame_tick = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.busy) cnt++;
            bus.frame_tick = (k == 5);
            clk1();
        end
        bus.frame_tick = 1'b0;
        bus.ce = 1'b0;
        chk("t5_busy", 32'(cnt), 32'd12);
        chk("t5_ovr", 32'(bus.ovr), 32'h1);
        chk("t5_collide", 32'(bus.rd_seg), 32'h8001);

        // 6: reset at sweep row 5
        bus.frame_tick = 1'b1;
        clk1();
        bus.frame_tick = 1'b0;
        clkn(5);
        chk("t6_busy_pre", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        clk1();
        reset = 1'b0;
        chk("t6_busy", 32'(bus.busy), 32'h0);
        chk("t6_ovr", 32'(bus.ovr), 32'h0);
        for (int r = 0; r < 12; r++) begin
            bus.rd_addr = 4'(r);
            clk1();
            chk($sformatf("t6_row%0d", r), 32'(bus.rd_seg), 32'h0);
        end
        bus.rd_addr = 4'd0;
        sweep(cnt);
        chk("t6_sweep", 32'(cnt), 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vfd_capture.md
Name: vfd_capture

Overview:
- Downstream consumer of the uCOM-43 CPU's output ports in the Tomy Scramble core.
- Takes the multiplexed VFD grid and segment lines, which the top level maps from CPU ports C..I.
- Rejects transient port states while firmware rewrites ports across several instructions, and holds a per-cell persistence level that models phosphor afterglow.
- Serves a registered, row-addressed read port to the video renderer.

Parameters:
NGRID, 12, number of grid lines (rows); 1..16
NSEG, 16, number of segment lines (columns); 1..32
SETTLE, 3, consecutive identical ce-samples, after the first, required before capture; 1..15
DECAY, 4, level loaded on capture = number of frame sweeps a lit cell persists; 1..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ce  in  1  sample enable (CPU instruction-rate strobe)
grid_in  in  NGRID  grid lines, 1 = grid driven
seg_in  in  NSEG  segment lines, 1 = segment driven
frame_tick  in  1  one-clk pulse per video frame; starts a decay sweep
rd_addr  in  4  row to read
rd_seg  out  NSEG  lit mask of row rd_addr, registered
busy  out  1  decay sweep in progress
ovr  out  1  sticky: frame_tick arrived while busy

Behaviour:
- Interface:
  - One clock, clk. Reset is synchronous and active-high on reset.
  - Everything updates on posedge clk. Only the sampler is gated by ce. Sweep and read run every clk.
- Storage: level[g][s], 4-bit, g<NGRID, s<NSEG. Cell lit ⇔ level≠0.
- Reset values:
  - all level 0; grid_q=0, seg_q=0, stab=0.
  - sweep idle, row=0.
  - rd_seg=0, busy=0, ovr=0.
  - Reset mid-sweep aborts the sweep immediately.
- Sampler (ce=1 only; ce=0 holds all sampler state):
  - {grid_in,seg_in}≠{grid_q,seg_q}: grid_q/seg_q ← inputs, stab←0.
  - Equal and stab<SETTLE-1: stab←stab+1.
  - Equal and stab=SETTLE-1: stab←SETTLE; capture event this edge.
  - Equal and stab=SETTLE: hold, no further capture. Exactly one capture per stable period.
  - Net effect: capture on the (SETTLE+1)-th consecutive identical ce-sample.
- Capture: for every g with grid_in[g]=1 and every s with seg_in[s]=1, level[g][s]←DECAY.
  - Cells with seg_in[s]=0 are unchanged; decay alone extinguishes them.
  - grid_in=0 → no effect.
  - Multiple active grids all load.
- Sweep FSM, states IDLE / SWEEP:
  - IDLE & frame_tick → SWEEP, row←0, busy←1.
  - SWEEP: each clk, every nonzero level[row][s] decrements by 1 (never below 0).
    - row<NGRID-1: row←row+1.
    - Otherwise → IDLE, busy←0.
  - A sweep takes exactly NGRID clks. busy rises the edge after frame_tick and falls after the last row.
  - frame_tick while in SWEEP: ignored, ovr←1. ovr clears only on reset.
  - frame_tick on the same edge the sweep finishes: ignored, ovr←1.
- Collision: capture and sweep on the same cell in the same edge → capture wins (level=DECAY, no decrement). Captures on other rows proceed in parallel with the sweep.
- Read port:
  - rd_seg[s] ← (level[rd_addr][s]≠0), one-clk latency.
  - rd_addr ≥ NGRID → rd_seg←0.
  - A write at edge k is visible in rd_seg at edge k+1.
- Widths: level 4 bits unsigned. DECAY truncated to 4 bits. No wrap: decrement is gated on nonzero.

Test Plan:
1. Capture: after reset, hold grid_in=12'h001, seg_in=16'h8001, ce every 4th clk. No capture on ce#1..3. On ce#4, level row0 bits 0,15 = 4. rd_addr=0 gives rd_seg=16'h8001 one clk later, and 0 before.
2. Glitch: same as 1 but seg_in=16'h8003 at ce#3, then 16'h8001 again. No capture until 4 further identical ce-samples. rd_seg stays 0 meanwhile.
3. Decay: after capture in 1, issue frame_tick four times, spaced 20 clks. busy high exactly 12 clks each time. rd_seg=16'h8001 after sweeps 1–3; 0 after sweep 4 completes.
4. Multi-grid: grid_in=12'h0C0, seg_in=16'h00F0, stable capture. Rows 6 and 7 read 16'h00F0; rows 5 and 8 read 0; rd_addr=12 reads 0.
5. Collision/overrun: row0 lit at level 1; align capture of row0 with the sweep cycle at row0 → level 4 (not 0). Second frame_tick 5 clks into the sweep → ovr=1; sweep still ends after 12 clks.
6. Reset mid-sweep: assert reset at sweep row 5 → next clk busy=0, ovr=0. All rows read 0. A new frame_tick starts a sweep from row0.
